irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller sitting directly downstream of the timer. It consumes the timer's timeout level plus other peripheral sources and turns rising edges into latched pending interrupts.
- Applies a software-written enable mask and picks the highest-priority enabled pending source.
- Presents one request with a vector to the CPU control unit over a req/ack/done handshake; no nesting.
- Enable/pending state is readable on a 16-bit register-out bus, same style as the timer's register output.

Parameters:
- NUM_SRC, 4, number of interrupt sources (legal 1..8). Source 0 is wired to the timer timeout.
- VEC_W, 3, width of irq_vec. Must satisfy 2**VEC_W >= NUM_SRC.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- DATA  in  16  data bus; bits [NUM_SRC-1:0] are used by mask_in and pend_clr_in.
- irq_src  in  NUM_SRC  level sources; bit 0 = timer timeout.
- mask_in  in  1  strobe: enable <= DATA[NUM_SRC-1:0] (1 = enabled).
- pend_clr_in  in  1  strobe: write-1-to-clear pending bits from DATA[NUM_SRC-1:0].
- irq_ack  in  1  CPU accepts the current request.
- irq_done  in  1  CPU finished the service routine (return-from-interrupt).
- irq  out  1  interrupt request to CPU.
- irq_vec  out  VEC_W  index of the requested source; valid while irq=1.
- REG_OUT_IRQ  out  16  status word: {zero pad, pending[NUM_SRC-1:0] at [15:8], enable[NUM_SRC-1:0] at [7:0]}; unused bits read 0.

Behaviour:
- Reset value of every output: irq=0, irq_vec=0, REG_OUT_IRQ=0.
- Internal reset values: pending=0, enable=0, state=IDLE, src_prev=all ones. A source already high out of reset does not fire.
- Edge detect: src_prev <= irq_src every cycle. rise = irq_src & ~src_prev. pending |= rise at the clock edge.
- Clear: pend_clr_in clears the DATA-selected pending bits. A rise in the same cycle as a clear of the same bit wins, so the bit stays set.
- Enable write takes effect on the next cycle. Pending bits of disabled sources are still latched; they raise irq once enabled.
- Priority: lowest index wins among (pending & enable).
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if (pending & enable) != 0, latch winner into irq_vec, set irq=1, go to REQ. irq is registered.
  - Latency: source rises before edge k → pending set after edge k → irq=1 after edge k+1.
  - REQ: irq and irq_vec are held stable regardless of mask changes or new pending bits. On irq_ack: clear pending[irq_vec] (a same-cycle new rise on that bit re-sets it), set irq=0, go to SERVICE.
  - SERVICE: irq=0. Pending bits keep accumulating. On irq_done, go to IDLE; a new request may issue on the following edge.
  - irq_done outside SERVICE is ignored. irq_ack outside REQ is ignored.
  - If a pend_clr_in clears pending[irq_vec] while in REQ, the request still completes normally on ack.
- REG_OUT_IRQ is the registered pending/enable state; it reflects updates one cycle after the causing edge.
- Reset mid-operation (any state) returns everything to reset values; in-flight requests are lost.
- The timer's timeout stays high until the timer is reloaded, so only one edge is produced per expiry.

Decomposition:
- Shared package holds the state encoding constants (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2) and the status field offsets (PEND_LSB=8, EN_LSB=0).
- One natural sub-module: irq_prio_enc, a combinational lowest-index-first encoder producing {any, index[VEC_W-1:0]}. The FSM, edge detect and registers stay in irq_ctrl.

Test Plan:
- Reset, then hold irq_src=4'b0001 high from reset release → no irq ever; REG_OUT_IRQ=16'h0000.
- mask_in with DATA=16'h0001; timer src0 rises → pending set after edge k; irq=1, irq_vec=0 after edge k+1; REG_OUT_IRQ=16'h0101.
- From the previous state, assert irq_ack → irq=0, pending0=0; irq_done → IDLE; no re-request.
- Enable=4'hF; src2 and src1 rise in the same cycle → irq_vec=1. After ack and done → irq_vec=2 on the next request.
- While in REQ with vec=1, write mask DATA=16'h0000 → irq stays 1, vec stays 1 until ack.
- pend_clr_in with DATA=16'h0004 in the same cycle src2 rises → pending2 remains 1. A src3 rise while enable3=0 → pending3=1 and irq=0 until enable3 is set.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: constants shared by the interrupt controller files.
//   - FSM state encoding (IDLE / REQ / SERVICE), kept as plain 2-bit
//     constants so they can be compared against legacy dumps directly.
//   - Field offsets of the 16-bit status word driven on REG_OUT_IRQ.
package irq_ctrl_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  // Status word layout: pending bits from bit 8 upward, enable bits from bit 0.
  localparam int PEND_LSB = 8;
  localparam int EN_LSB   = 0;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index-first priority encoder.
// Ports:
//   req_i  [N-1:0]  candidate sources (pending & enabled)
//   any_o           at least one candidate present
//   idx_o  [W-1:0]  index of the lowest set bit of req_i (0 when none)
module irq_prio_enc #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  output logic         any_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // it unassigned and no latch is inferred.
    any_o = |req_i;
    idx_o = '0;
    // Scan downward so the last hit, which is the lowest index, wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller downstream of the timer.
// Turns rising edges on irq_src into latched pending bits, masks them with a
// software-written enable register, and offers the lowest-index enabled
// pending source to the CPU over an irq / irq_ack / irq_done handshake
// (one request at a time, no nesting).
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   DATA         write data; bits [NUM_SRC-1:0] feed mask_in / pend_clr_in
//   irq_src      level sources, bit 0 is the timer timeout
//   mask_in      strobe: enable <= DATA[NUM_SRC-1:0]
//   pend_clr_in  strobe: write-1-to-clear pending bits from DATA
//   irq_ack      CPU accepts the current request
//   irq_done     CPU returned from the service routine
//   irq          registered interrupt request
//   irq_vec      index of the requested source, valid while irq=1
//   REG_OUT_IRQ  {pending at [15:8], enable at [7:0]}, unused bits 0
// NUM_SRC must be 1..8 and 2**VEC_W must be >= NUM_SRC.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int VEC_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  DATA,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_in,
  input  logic               pend_clr_in,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic               irq,
  output logic [VEC_W-1:0]   irq_vec,
  output logic [DATA_W-1:0]  REG_OUT_IRQ
);

  logic [NUM_SRC-1:0] src_prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [1:0]         state_q, state_d;
  logic               irq_q, irq_d;
  logic [VEC_W-1:0]   irq_vec_q, irq_vec_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr_sel;
  logic [NUM_SRC-1:0] ack_clr;
  logic               win_any;
  logic [VEC_W-1:0]   win_idx;

  // Upper DATA bits carry nothing for this block.
  logic unused_data;
  assign unused_data = ^DATA[DATA_W-1:NUM_SRC];

  irq_prio_enc #(
    .N (NUM_SRC),
    .W (VEC_W)
  ) u_prio (
    .req_i (pending_q & enable_q),
    .any_o (win_any),
    .idx_o (win_idx)
  );

  always_comb begin
    rise    = irq_src & ~src_prev_q;
    clr_sel = pend_clr_in ? DATA[NUM_SRC-1:0] : '0;
    ack_clr = '0;

    state_d   = state_q;
    irq_d     = irq_q;
    irq_vec_d = irq_vec_q;

    case (state_q)
      IDLE: begin
        if (win_any) begin
          irq_d     = 1'b1;
          irq_vec_d = win_idx;
          state_d   = REQ;
        end
      end
      // irq / irq_vec are frozen here: mask writes and new pending bits
      // cannot disturb a request the CPU may already be decoding.
      REQ: begin
        if (irq_ack) begin
          ack_clr = NUM_SRC'(1) << irq_vec_q;
          irq_d   = 1'b0;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (irq_done) state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Rise is OR-ed in last so a same-cycle edge beats either kind of clear.
    pending_d = (pending_q & ~clr_sel & ~ack_clr) | rise;
    enable_d  = mask_in ? DATA[NUM_SRC-1:0] : enable_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, matching real hardware.
    if (reset) begin
      // All ones: a source already high when reset releases has no edge.
      src_prev_q <= '1;
      pending_q  <= '0;
      enable_q   <= '0;
      state_q    <= IDLE;
      irq_q      <= 1'b0;
      irq_vec_q  <= '0;
    end else begin
      src_prev_q <= irq_src;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      state_q    <= state_d;
      irq_q      <= irq_d;
      irq_vec_q  <= irq_vec_d;
    end
  end

  assign irq     = irq_q;
  assign irq_vec = irq_vec_q;

  always_comb begin
    REG_OUT_IRQ = '0;
    REG_OUT_IRQ[PEND_LSB +: NUM_SRC] = pending_q;
    REG_OUT_IRQ[EN_LSB   +: NUM_SRC] = enable_q;
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: self-checking bench for irq_ctrl (NUM_SRC=4, VEC_W=3).
// A behavioural model tracks pending/enable/handshake phase from the
// controller's rules; a compare process checks the DUT against it on every
// falling edge. Directed steps pin the model with hand-computed literals,
// then a long randomized run exercises edges, strobes, handshakes and resets.
module tb_irq_ctrl;

  localparam int NS = 4;
  localparam int VW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   data;
  logic [NS-1:0] src;
  logic          mask_s, clr_s, ack_s, done_s;
  logic          irq;
  logic [VW-1:0] irq_vec;
  logic [15:0]   reg_out;

  irq_ctrl #(.NUM_SRC(NS), .VEC_W(VW)) dut (
    .clk         (clk),
    .reset       (reset),
    .DATA        (data),
    .irq_src     (src),
    .mask_in     (mask_s),
    .pend_clr_in (clr_s),
    .irq_ack     (ack_s),
    .irq_done    (done_s),
    .irq         (irq),
    .irq_vec     (irq_vec),
    .REG_OUT_IRQ (reg_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {PH_IDLE, PH_ASKING, PH_SERVICING} phase_t;

  logic [NS-1:0] m_pend, m_en, m_prev;
  phase_t        m_phase;
  logic          m_irq;
  int            m_vec;

  function automatic int lowest_set(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pend  <= '0;
      m_en    <= '0;
      m_prev  <= '1;
      m_phase <= PH_IDLE;
      m_irq   <= 1'b0;
      m_vec   <= 0;
    end else begin
      logic [NS-1:0] p;
      int w;
      p = m_pend;
      if (clr_s) p = p & ~data[NS-1:0];
      if (m_phase == PH_ASKING && ack_s) p[m_vec] = 1'b0;
      p = p | (src & ~m_prev);
      m_pend <= p;
      m_prev <= src;
      if (mask_s) m_en <= data[NS-1:0];
      case (m_phase)
        PH_IDLE: begin
          w = lowest_set(m_pend & m_en);
          if (w >= 0) begin
            m_irq   <= 1'b1;
            m_vec   <= w;
            m_phase <= PH_ASKING;
          end
        end
        PH_ASKING: if (ack_s) begin
          m_irq   <= 1'b0;
          m_phase <= PH_SERVICING;
        end
        default: if (done_s) m_phase <= PH_IDLE;
      endcase
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("irq", {15'd0, irq}, {15'd0, m_irq});
      if (m_irq) check("irq_vec", {13'd0, irq_vec}, 16'(m_vec));
      check("reg_out", reg_out, {4'd0, m_pend, 4'd0, m_en});
    end
  end

  // Drive one cycle of inputs at a falling edge; return at the next falling
  // edge, after the rising edge has consumed them.
  task automatic step(input logic [NS-1:0] s, input logic [15:0] d,
                      input logic m, input logic c, input logic a, input logic dn);
    src = s; data = d; mask_s = m; clr_s = c; ack_s = a; done_s = dn;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    src = '0; data = '0; mask_s = 0; clr_s = 0; ack_s = 0; done_s = 0;
    @(negedge clk);

    // Reset with timer source already high: no edge, no request.
    repeat (2) step(4'b0001, 16'h0, 0, 0, 0, 0);
    cmp_en = 1'b1;
    check("rst_irq", {15'd0, irq}, 16'd0);
    check("rst_vec", {13'd0, irq_vec}, 16'd0);
    check("rst_reg", reg_out, 16'h0000);
    reset = 1'b0;
    repeat (5) step(4'b0001, 16'h0, 0, 0, 0, 0);
    check("held_src_no_irq", {15'd0, irq}, 16'd0);
    check("held_src_reg", reg_out, 16'h0000);

    // Enable src0, then a fresh timer edge.
    step(4'b0000, 16'h0000, 0, 0, 0, 0);
    step(4'b0000, 16'h0001, 1, 0, 0, 0);
    step(4'b0001, 16'h0000, 0, 0, 0, 0);  // edge k
    check("k_pending_reg", reg_out, 16'h0101);
    check("k_irq_low", {15'd0, irq}, 16'd0);
    step(4'b0001, 16'h0000, 0, 0, 0, 0);  // edge k+1
    check("k1_irq", {15'd0, irq}, 16'd1);
    check("k1_vec", {13'd0, irq_vec}, 16'd0);

    // Ack, done, no re-request.
    step(4'b0001, 16'h0000, 0, 0, 1, 0);
    check("ack_irq_low", {15'd0, irq}, 16'd0);
    check("ack_clr_pend", reg_out, 16'h0001);
    step(4'b0001, 16'h0000, 0, 0, 0, 1);
    repeat (3) step(4'b0001, 16'h0000, 0, 0, 0, 0);
    check("no_rerequest", {15'd0, irq}, 16'd0);

    // Enable all; src1 and src2 rise together, lowest index first.
    step(4'b0001, 16'h000F, 1, 0, 0, 0);
    step(4'b0111, 16'h0000, 0, 0, 0, 0);
    check("two_pend_reg", reg_out, 16'h060F);
    step(4'b0111, 16'h0000, 0, 0, 0, 0);
    check("prio_irq", {15'd0, irq}, 16'd1);
    check("prio_vec1", {13'd0, irq_vec}, 16'd1);

    // Mask everything while in REQ: request is held.
    step(4'b0111, 16'h0000, 1, 0, 0, 0);
    check("masked_irq_held", {15'd0, irq}, 16'd1);
    check("masked_vec_held", {13'd0, irq_vec}, 16'd1);
    check("masked_reg", reg_out, 16'h0600);
    step(4'b0111, 16'h000F, 1, 0, 0, 0);
    step(4'b0111, 16'h0000, 0, 0, 1, 0);
    check("ack1_reg", reg_out, 16'h040F);
    step(4'b0111, 16'h0000, 0, 0, 0, 1);
    step(4'b0111, 16'h0000, 0, 0, 0, 0);
    check("second_irq", {15'd0, irq}, 16'd1);
    check("second_vec2", {13'd0, irq_vec}, 16'd2);
    step(4'b0111, 16'h0000, 0, 0, 1, 0);
    step(4'b0111, 16'h0000, 0, 0, 0, 1);

    // Clear racing a rise on src2: the rise wins.
    step(4'b0001, 16'h0000, 1, 0, 0, 0);
    step(4'b0101, 16'h0004, 0, 1, 0, 0);
    check("rise_beats_clr", reg_out, 16'h0400);
    // src3 rises while disabled: latched, no request.
    step(4'b1101, 16'h0000, 0, 0, 0, 0);
    check("pend3_disabled", reg_out, 16'h0C00);
    step(4'b1101, 16'h0000, 0, 0, 0, 0);
    check("disabled_no_irq", {15'd0, irq}, 16'd0);
    step(4'b1101, 16'h0008, 1, 0, 0, 0);
    check("en3_reg", reg_out, 16'h0C08);
    check("en3_not_yet", {15'd0, irq}, 16'd0);
    step(4'b1101, 16'h0000, 0, 0, 0, 0);
    check("en3_irq", {15'd0, irq}, 16'd1);
    check("en3_vec", {13'd0, irq_vec}, 16'd3);
    // Software clears the in-flight pending bit; request still completes.
    step(4'b1101, 16'h0008, 0, 1, 0, 0);
    check("clr_inflight_irq", {15'd0, irq}, 16'd1);
    check("clr_inflight_reg", reg_out, 16'h0408);
    step(4'b1101, 16'h0000, 0, 0, 1, 0);
    check("clr_inflight_ack", {15'd0, irq}, 16'd0);
    step(4'b1101, 16'h0000, 0, 0, 0, 1);

    // Randomized run, including occasional mid-operation reset.
    for (int n = 0; n < 3000; n++) begin
      logic [NS-1:0] flip;
      for (int b = 0; b < NS; b++) flip[b] = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 199) == 0);
      step(src ^ flip, 16'($urandom),
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end
    reset = 1'b0;
    step(src, 16'h0000, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
